// File: rtl/key_pkg.sv
// Shared types and key-code constants for the keyboard event decoder.
package key_pkg;

    // Event kinds carried through the event FIFO.
    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_REPEAT  = 2'd2
    } evt_type_t;

    // Per-key auto-repeat state.
    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2
    } rep_state_t;

    // An empty keycode slot.
    localparam logic [7:0] KEY_EMPTY = 8'h00;

    // USB HID usage codes for the arrow keys.
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_UP    = 8'h52;

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through FIFO for decoded key events.
// Head word is shown on rd_data whenever the FIFO is not empty.
module key_evt_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Status flags, guarded handshakes and next pointer values.
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers; the extra MSB separates full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; empty pointers make stale words invisible and rd_data reads 0.
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/key_event_decoder.sv
// Keyboard decoder: matches HID keycode slots against configured keys and
// produces held levels, press/release/repeat pulses and a queued event stream.
module key_event_decoder
    import key_pkg::*;
#(
    parameter int                    NUM_SLOTS     = 4,
    parameter int                    NUM_KEYS      = 4,
    parameter logic [NUM_KEYS*8-1:0] KEY_CODES     = {KEY_LEFT, KEY_DOWN, KEY_UP, KEY_RIGHT},
    parameter int                    REPEAT_DELAY  = 30,
    parameter int                    REPEAT_PERIOD = 8,
    parameter int                    EVT_DEPTH     = 8,
    localparam int                   KW            = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                   pxl_clk,
    input  logic                   reset,
    input  logic [8*NUM_SLOTS-1:0] keycode,
    output logic [NUM_KEYS-1:0]    held,
    output logic [NUM_KEYS-1:0]    press,
    output logic [NUM_KEYS-1:0]    release_p,
    output logic [NUM_KEYS-1:0]    repeat_p,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [1:0]             evt_type,
    output logic [KW-1:0]          evt_key,
    output logic                   evt_overflow
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = $clog2(REP_MAX + 1);
    localparam int EW      = 2 + KW;
    localparam logic [CW-1:0] DELAY_C  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PERIOD_C = CW'(REPEAT_PERIOD);

    logic [8*NUM_SLOTS-1:0] kc_q;
    logic [NUM_KEYS-1:0]    match;
    logic [NUM_KEYS-1:0]    held_q, press_q, release_q, repeat_q;
    logic [NUM_KEYS-1:0]    press_d, release_d, repeat_d;
    logic [NUM_KEYS-1:0]    pend_prs_q, pend_rel_q, pend_rep_q;
    logic [NUM_KEYS-1:0]    pend_prs_d, pend_rel_d, pend_rep_d;
    logic [NUM_KEYS-1:0]    sel_prs, sel_rel, sel_rep;
    logic [NUM_KEYS-1:0]    gnt_prs, gnt_rel, gnt_rep;
    logic                   ovf_q, ovf_d;
    logic                   found, can_push, fifo_pop, fifo_full, fifo_empty;
    evt_type_t              push_type;
    logic [KW-1:0]          push_key;
    logic [EW-1:0]          head;

    // Slot match: a key is down if any slot carries its code.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (kc_q[8*s +: 8] != KEY_EMPTY && kc_q[8*s +: 8] == KEY_CODES[8*i +: 8]) begin
                    match[i] = 1'b1;
                end
            end
        end
        press_d   = match & ~held_q;
        release_d = ~match & held_q;
    end

    // Per-key auto-repeat FSMs.
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_rep
        rep_state_t    state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          rep_d;

        // Next state: release wins, otherwise count towards the next repeat.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rep_d   = 1'b0;
            if (release_d[k]) begin
                state_d = REP_IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    REP_IDLE: begin
                        if (press_d[k]) begin
                            state_d = REP_DELAY;
                            cnt_d   = CW'(1);
                        end
                    end
                    REP_DELAY: begin
                        if (cnt_q == DELAY_C) begin
                            rep_d   = 1'b1;
                            state_d = REP_REPEAT;
                            cnt_d   = CW'(1);
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    REP_REPEAT: begin
                        if (cnt_q == PERIOD_C) begin
                            rep_d = 1'b1;
                            cnt_d = CW'(1);
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_d = REP_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        // Repeat FSM state and counter.
        always_ff @(posedge pxl_clk) begin
            if (reset) begin
                state_q <= REP_IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign repeat_d[k] = rep_d;
    end

    // Arbiter: lowest key first; within a key PRESS, then REPEAT, then RELEASE.
    always_comb begin
        sel_prs   = '0;
        sel_rel   = '0;
        sel_rep   = '0;
        found     = 1'b0;
        push_type = EVT_PRESS;
        push_key  = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!found) begin
                if (pend_prs_q[i] || press_q[i]) begin
                    sel_prs[i] = 1'b1;
                    found      = 1'b1;
                    push_type  = EVT_PRESS;
                    push_key   = KW'(i);
                end else if (pend_rep_q[i] || repeat_q[i]) begin
                    sel_rep[i] = 1'b1;
                    found      = 1'b1;
                    push_type  = EVT_REPEAT;
                    push_key   = KW'(i);
                end else if (pend_rel_q[i] || release_q[i]) begin
                    sel_rel[i] = 1'b1;
                    found      = 1'b1;
                    push_type  = EVT_RELEASE;
                    push_key   = KW'(i);
                end
            end
        end
        fifo_pop = evt_valid && evt_ready;
        can_push = !fifo_full || fifo_pop;
        gnt_prs  = can_push ? sel_prs : '0;
        gnt_rep  = can_push ? sel_rep : '0;
        gnt_rel  = can_push ? sel_rel : '0;
        // A granted bit keeps only a second copy that arrived alongside it;
        // an ungranted bit that was already set drops the new pulse.
        pend_prs_d = (gnt_prs & pend_prs_q & press_q)   | (~gnt_prs & (pend_prs_q | press_q));
        pend_rep_d = (gnt_rep & pend_rep_q & repeat_q)  | (~gnt_rep & (pend_rep_q | repeat_q));
        pend_rel_d = (gnt_rel & pend_rel_q & release_q) | (~gnt_rel & (pend_rel_q | release_q));
        ovf_d = ovf_q
              | (|(~gnt_prs & pend_prs_q & press_q))
              | (|(~gnt_rep & pend_rep_q & repeat_q))
              | (|(~gnt_rel & pend_rel_q & release_q));
    end

    // Keycode pipeline, key levels and pulses, pending bits, sticky overflow.
    always_ff @(posedge pxl_clk) begin
        if (reset) begin
            kc_q       <= '0;
            held_q     <= '0;
            press_q    <= '0;
            release_q  <= '0;
            repeat_q   <= '0;
            pend_prs_q <= '0;
            pend_rel_q <= '0;
            pend_rep_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            kc_q       <= keycode;
            held_q     <= match;
            press_q    <= press_d;
            release_q  <= release_d;
            repeat_q   <= repeat_d;
            pend_prs_q <= pend_prs_d;
            pend_rel_q <= pend_rel_d;
            pend_rep_q <= pend_rep_d;
            ovf_q      <= ovf_d;
        end
    end

    key_evt_fifo #(
        .WIDTH (EW),
        .DEPTH (EVT_DEPTH)
    ) u_fifo (
        .clk     (pxl_clk),
        .reset   (reset),
        .push    (found && can_push),
        .wr_data ({push_type, push_key}),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign held         = held_q;
    assign press        = press_q;
    assign release_p    = release_q;
    assign repeat_p     = repeat_q;
    assign evt_valid    = !fifo_empty;
    assign evt_type     = head[EW-1:KW];
    assign evt_key      = head[KW-1:0];
    assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed self-checking bench for key_event_decoder (event FIFO depth 2).
module tb_key_event_decoder;

    logic        pxl_clk = 1'b0;
    logic        reset;
    logic [31:0] keycode;
    logic [3:0]  held, press, release_p, repeat_p;
    logic        evt_valid, evt_ready, evt_overflow;
    logic [1:0]  evt_type;
    logic [1:0]  evt_key;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] t;
        logic [1:0] k;
    } ev_t;

    ev_t log_q[$];
    int  rep_seen0 = 0;
    int  log_base;
    int  rep_base;

    key_event_decoder #(
        .NUM_SLOTS     (4),
        .NUM_KEYS      (4),
        .REPEAT_DELAY  (30),
        .REPEAT_PERIOD (8),
        .EVT_DEPTH     (2)
    ) dut (
        .pxl_clk      (pxl_clk),
        .reset        (reset),
        .keycode      (keycode),
        .held         (held),
        .press        (press),
        .release_p    (release_p),
        .repeat_p     (repeat_p),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_type     (evt_type),
        .evt_key      (evt_key),
        .evt_overflow (evt_overflow)
    );

    always #5 pxl_clk = ~pxl_clk;

    // Record accepted events and key-0 repeat pulses away from the active edge.
    always @(negedge pxl_clk) begin
        if (evt_valid && evt_ready) log_q.push_back('{evt_type, evt_key});
        if (repeat_p[0]) rep_seen0++;
    end

    task automatic tick();
        @(posedge pxl_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_evt(input string tag, input int idx, input logic [1:0] t, input logic [1:0] k);
        ev_t e;
        if (log_base + idx < log_q.size()) e = log_q[log_base + idx];
        else e = '{2'bxx, 2'bxx};
        check({tag, "_type"}, {30'd0, e.t}, {30'd0, t});
        check({tag, "_key"},  {30'd0, e.k}, {30'd0, k});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_held"},  {28'd0, held}, 32'd0);
        check({tag, "_press"}, {28'd0, press}, 32'd0);
        check({tag, "_rel"},   {28'd0, release_p}, 32'd0);
        check({tag, "_rep"},   {28'd0, repeat_p}, 32'd0);
        check({tag, "_valid"}, {31'd0, evt_valid}, 32'd0);
        check({tag, "_type"},  {30'd0, evt_type}, 32'd0);
        check({tag, "_key"},   {30'd0, evt_key}, 32'd0);
        check({tag, "_ovf"},   {31'd0, evt_overflow}, 32'd0);
    endtask

    initial begin
        logic [1:0] exp_t [8];
        logic [1:0] exp_k [8];

        // Reset state
        reset = 1'b1; keycode = '0; evt_ready = 1'b0;
        tick(); tick();
        check_idle_outputs("reset");
        reset = 1'b0;

        // Single press of LEFT (key 3) in slot 1 for 5 cycles
        evt_ready = 1'b1;
        log_base  = log_q.size();
        keycode   = 32'h0000_5000;
        tick(); check("t1_held_n", {28'd0, held}, 32'h0);
        tick(); check("t1_held_n1", {28'd0, held}, 32'h8);
                check("t1_press", {28'd0, press}, 32'h8);
        tick(); check("t1_press_gone", {28'd0, press}, 32'h0);
                check("t1_valid", {31'd0, evt_valid}, 32'd1);
                check("t1_type", {30'd0, evt_type}, 32'd0);
                check("t1_key", {30'd0, evt_key}, 32'd3);
        tick(); check("t1_popped", {31'd0, evt_valid}, 32'd0);
        tick(); keycode = '0;
        tick(); check("t1_held_last", {28'd0, held}, 32'h8);
        tick(); check("t1_held_off", {28'd0, held}, 32'h0);
                check("t1_release", {28'd0, release_p}, 32'h8);
        tick(); check("t1_rel_valid", {31'd0, evt_valid}, 32'd1);
                check("t1_rel_type", {30'd0, evt_type}, 32'd1);
                check("t1_rel_key", {30'd0, evt_key}, 32'd3);
        tick(); check("t1_drained", {31'd0, evt_valid}, 32'd0);
        check("t1_nevents", log_q.size() - log_base, 32'd2);
        check_evt("t1_ev0", 0, 2'd0, 2'd3);
        check_evt("t1_ev1", 1, 2'd1, 2'd3);

        // Auto-repeat: RIGHT (key 0) in slot 2 for 60 cycles
        log_base = log_q.size();
        rep_base = rep_seen0;
        keycode  = 32'h004F_0000;
        for (int c = 1; c <= 60; c++) begin
            tick();
            check($sformatf("t2_rep_c%0d", c), {31'd0, repeat_p[0]},
                  {31'd0, (c == 32 || c == 40 || c == 48 || c == 56)});
        end
        keycode = '0;
        repeat (20) tick();
        check("t2_rep_count", rep_seen0 - rep_base, 32'd4);
        check("t2_held_off", {28'd0, held}, 32'h0);
        check("t2_nevents", log_q.size() - log_base, 32'd6);
        check_evt("t2_ev0", 0, 2'd0, 2'd0);
        for (int j = 1; j <= 4; j++) check_evt($sformatf("t2_ev%0d", j), j, 2'd2, 2'd0);
        check_evt("t2_ev5", 5, 2'd1, 2'd0);

        // Multi-key: all four arrows in one cycle
        log_base = log_q.size();
        keycode  = 32'h4F50_5152;
        tick(); tick();
        check("t3_held", {28'd0, held}, 32'hF);
        check("t3_press", {28'd0, press}, 32'hF);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t3_valid%0d", k), {31'd0, evt_valid}, 32'd1);
            check($sformatf("t3_type%0d", k), {30'd0, evt_type}, 32'd0);
            check($sformatf("t3_key%0d", k), {30'd0, evt_key}, k);
        end
        tick(); check("t3_empty", {31'd0, evt_valid}, 32'd0);
        keycode = '0;
        repeat (8) tick();
        check("t3_held_off", {28'd0, held}, 32'h0);
        check("t3_nevents", log_q.size() - log_base, 32'd8);
        for (int k = 0; k < 4; k++) check_evt($sformatf("t3_rel%0d", k), 4 + k, 2'd1, 2'(k));

        // Duplicate code in two slots, remaining slots empty
        log_base = log_q.size();
        keycode  = 32'h5050_0000;
        tick(); tick();
        check("t4_held", {28'd0, held}, 32'h8);
        check("t4_press", {28'd0, press}, 32'h8);
        tick(); check("t4_press_once", {28'd0, press}, 32'h0);
        keycode = '0;
        repeat (6) tick();
        check("t4_no_match", {28'd0, held}, 32'h0);
        check("t4_nevents", log_q.size() - log_base, 32'd2);
        check_evt("t4_ev0", 0, 2'd0, 2'd3);
        check_evt("t4_ev1", 1, 2'd1, 2'd3);

        // Backpressure with a two-entry FIFO
        evt_ready = 1'b0;
        log_base  = log_q.size();
        keycode   = 32'h4F50_5152;
        repeat (6) tick();
        check("t5_full_valid", {31'd0, evt_valid}, 32'd1);
        check("t5_head_type", {30'd0, evt_type}, 32'd0);
        check("t5_head_key", {30'd0, evt_key}, 32'd0);
        check("t5_no_ovf", {31'd0, evt_overflow}, 32'd0);
        keycode = '0;
        tick(); tick();
        check("t5_release", {28'd0, release_p}, 32'hF);
        keycode = 32'h0000_0050;
        tick(); tick();
        check("t5_repress", {28'd0, press}, 32'h8);
        check("t5_ovf_before", {31'd0, evt_overflow}, 32'd0);
        tick(); check("t5_ovf_set", {31'd0, evt_overflow}, 32'd1);
        evt_ready = 1'b1;
        repeat (12) tick();
        check("t5_drained", {31'd0, evt_valid}, 32'd0);
        check("t5_ovf_sticky", {31'd0, evt_overflow}, 32'd1);
        check("t5_nevents", log_q.size() - log_base, 32'd8);
        exp_t[0] = 2'd0; exp_k[0] = 2'd0;
        exp_t[1] = 2'd0; exp_k[1] = 2'd1;
        exp_t[2] = 2'd1; exp_k[2] = 2'd0;
        exp_t[3] = 2'd1; exp_k[3] = 2'd1;
        exp_t[4] = 2'd0; exp_k[4] = 2'd2;
        exp_t[5] = 2'd1; exp_k[5] = 2'd2;
        exp_t[6] = 2'd0; exp_k[6] = 2'd3;
        exp_t[7] = 2'd1; exp_k[7] = 2'd3;
        for (int j = 0; j < 8; j++) check_evt($sformatf("t5_ev%0d", j), j, exp_t[j], exp_k[j]);
        reset = 1'b1; keycode = '0;
        tick();
        reset = 1'b0;
        tick();

        // Reset while UP (key 1) is repeating with events queued
        evt_ready = 1'b0;
        keycode   = 32'h0000_0052;
        repeat (49) tick();
        check("t6_ovf_pre", {31'd0, evt_overflow}, 32'd1);
        check("t6_valid_pre", {31'd0, evt_valid}, 32'd1);
        check("t6_head_key", {30'd0, evt_key}, 32'd1);
        log_base = log_q.size();
        reset = 1'b1;
        tick();
        check_idle_outputs("t6_flush");
        reset = 1'b0;
        tick(); check("t6_held_n", {28'd0, held}, 32'h0);
        tick(); check("t6_held", {28'd0, held}, 32'h2);
                check("t6_press", {28'd0, press}, 32'h2);
        evt_ready = 1'b1;
        tick(); check("t6_valid", {31'd0, evt_valid}, 32'd1);
                check("t6_type", {30'd0, evt_type}, 32'd0);
                check("t6_key", {30'd0, evt_key}, 32'd1);
        repeat (5) tick();
        check("t6_nevents", log_q.size() - log_base, 32'd1);
        check_evt("t6_ev0", 0, 2'd0, 2'd1);
        check("t6_ovf_clear", {31'd0, evt_overflow}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Parametrised keyboard decoder for the USB keycode word delivered by the host-side HID path. It tracks `NUM_KEYS` configurable key codes across `NUM_SLOTS` simultaneous-key slots. Per key it produces a level (`held`), press/release/auto-repeat pulses, and a queued event stream with valid/ready handshake. It sits between the keycode register and game/UI logic in the pixel-clock domain.

## Interface
Parameters:
- `NUM_SLOTS`, 4: 8-bit keycode slots in `keycode`; range 1–8.
- `NUM_KEYS`, 4: tracked keys; range 1–16.
- `KEY_CODES`, {8'h4F, 8'h52, 8'h51, 8'h50}: packed `NUM_KEYS`×8 array. Entry i is the code of key i (default order: right, up, down, left). No entry may be 8'h00.
- `REPEAT_DELAY`, 30: cycles of `held` before the first repeat; must be ≥ 1.
- `REPEAT_PERIOD`, 8: cycles between subsequent repeats; must be ≥ 1.
- `EVT_DEPTH`, 8: event FIFO depth; must be a power of 2, ≥ 2.

Ports:
- `pxl_clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `keycode` in 8·NUM_SLOTS: slot s occupies bits [8s+7:8s]. 8'h00 means the slot is empty.
- `held` out NUM_KEYS: key i is currently down.
- `press` out NUM_KEYS: one-cycle pulse when `held[i]` rises.
- `release` out NUM_KEYS: one-cycle pulse when `held[i]` falls.
- `repeat_p` out NUM_KEYS: one-cycle auto-repeat pulse.
- `evt_valid` out 1: FIFO head is valid.
- `evt_ready` in 1: consumer accepts the head.
- `evt_type` out 2: 0 = PRESS, 1 = RELEASE, 2 = REPEAT.
- `evt_key` out KW: key index, where KW = max(1, $clog2(NUM_KEYS)).
- `evt_overflow` out 1: sticky; cleared only by `reset`.

## Operation
- **Stage 1:** register `keycode` into `kc_q`.
- **Stage 2:** `match[i]` = OR over all slots of (`kc_q` slot == `KEY_CODES[i]`). The same code in several slots counts once. `held <= match`.
- `press[i]` = `held` rising edge; `release[i]` = `held` falling edge. Both are registered and coincide with the `held` transition cycle.
- **Per-key repeat FSM:**
  - States are IDLE, DELAY and REPEAT. Each key has a counter of width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
  - IDLE→DELAY on press; the counter loads 1.
  - DELAY: the counter increments. When it reaches REPEAT_DELAY, pulse `repeat_p`, go to REPEAT, and load 1.
  - REPEAT: when the counter reaches REPEAT_PERIOD, pulse `repeat_p` and reload 1.
  - Release from any state → IDLE, counter cleared, no repeat pulse that cycle.
- **Event pending:**
  - Each pulse sets pending bit `pend[type][i]`.
  - If a bit is already set when its pulse arrives, the event is dropped and `evt_overflow` is set.
- **Arbiter:**
  - Each cycle at most one pending bit is written into the FIFO, and only if the FIFO is not full.
  - The selected bit is cleared in the same cycle it is written.
  - Key priority: lowest index first. Within a key: PRESS > REPEAT > RELEASE, so a key's press never follows its own release.
  - A pulse arriving on the same cycle its bit is cleared re-sets the bit; it is not an overflow.
- **FIFO:**
  - Depth EVT_DEPTH, first-word-fall-through; the head is shown on `evt_*`.
  - Pop when `evt_valid && evt_ready`.
  - Simultaneous push and pop when full is legal: occupancy stays constant.
  - Pointers wrap modulo EVT_DEPTH and carry an extra bit to distinguish full from empty.
  - When full, pending bits are held and nothing is lost until a second same-type pulse arrives.

## Timing
- **Reset values:** all outputs 0. FSMs in IDLE, pending bits, FIFO and overflow cleared, `kc_q` = 0.
- **Latency:**
  - Keycode applied before edge N is registered into `kc_q` at edge N, and `held`/`press` become visible after edge N+1.
  - The event enters the FIFO at edge N+2; with the FIFO empty, `evt_valid` is high after edge N+2.
- **First repeat:** `repeat_p` occurs REPEAT_DELAY cycles after the `press` cycle, then every REPEAT_PERIOD cycles.
- **Handshake:** `evt_*` is stable while `evt_valid && !evt_ready`. `evt_ready` may be high with `evt_valid` low; nothing happens.
- **Reset mid-operation:** all state is flushed next edge. No release events are generated for keys held at reset.

## Structure
- Package `key_pkg`:
  - `evt_type_t` enum {EVT_PRESS, EVT_RELEASE, EVT_REPEAT}.
  - `rep_state_t` enum {REP_IDLE, REP_DELAY, REP_REPEAT}.
  - Constant `KEY_EMPTY` = 8'h00.
  - Default direction codes `KEY_RIGHT` = 8'h4F, `KEY_LEFT` = 8'h50, `KEY_DOWN` = 8'h51, `KEY_UP` = 8'h52.
- One sub-module, `key_evt_fifo`: parametrised width and depth, FWFT, single push and pop port, `full`/`empty` outputs.
- Decode, repeat FSMs and arbiter live in `key_event_decoder` and are generated per key.

## Test plan
- **Single press:** `keycode` = 32'h0000_5000 for 5 cycles, then 0, with `evt_ready` = 1.
  - `held[3]` high for 5 cycles, starting 2 cycles after the apply.
  - Events read (PRESS, 3) then (RELEASE, 3).
  - No repeat occurs.
- **Auto-repeat:** hold 8'h4F in slot 2 for 60 cycles with defaults.
  - `repeat_p[0]` at press+30, +38, +46, +54.
  - Four REPEAT events; the FSM is in IDLE after release.
- **Multi-key same cycle:** `keycode` = 32'h4F50_5152, all appearing at once.
  - `held` = 4'hF.
  - PRESS events in key order 0, 1, 2, 3 on consecutive cycles.
- **Duplicate slot / empty slot:** `keycode` = 32'h5050_0000.
  - Single `press[3]`; `held` = 4'b1000.
  - `keycode` = 0 gives no matches.
- **Backpressure / full:** `evt_ready` = 0 with EVT_DEPTH = 2, then toggle 4 keys.
  - FIFO holds 2 events; the rest stay pending with `evt_overflow` = 0.
  - A second press of a pending key sets `evt_overflow`.
  - With `evt_ready` = 1, all remaining events drain in priority order.
- **Reset mid-repeat:** assert `reset` for 1 cycle while key 1 is in REPEAT with 3 events queued.
  - Next cycle: all outputs 0, `evt_valid` = 0, overflow cleared.
  - With the key still held, PRESS re-issues 2 cycles after `reset` deasserts.
